data_mem_bus: RTL and testbench
===============================

DATA_MEM_BUS -- requirements
Module: data_mem_bus

Interface
REQ-001 The block SHALL have parameter RAM_WORDS, default 1024, giving the data RAM depth in 32-bit words; it must be a power of 2.
REQ-002 The block SHALL have parameter CLK_PER_BIT, default 16, giving the number of clk cycles per UART bit; the minimum is 2.
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 rst  input  1  synchronous, active-high reset; sampled on posedge clk.
REQ-005 i_mem_addr  input  30  word address from the core.
REQ-006 i_mem_data  input  32  store data, already lane-aligned by the core.
REQ-007 i_mem_we  input  1  store strobe; one write per cycle while high.
REQ-008 i_mem_mask  input  4  byte-lane enables; bit k enables bits [8k+7:8k].
REQ-009 o_mem_data  output  32  registered load data.
REQ-010 o_leds  output  8  LED register.
REQ-011 o_uart_tx  output  1  UART serial line; idles high.

Function
REQ-012 Address decode SHALL be: i_mem_addr[29]=0 selects RAM; i_mem_addr[29]=1 selects MMIO with word offset i_mem_addr[3:0].
REQ-013 RAM index SHALL be i_mem_addr modulo RAM_WORDS; out-of-range RAM addresses alias and are not an error.
REQ-014 A store with i_mem_we=1 SHALL update at posedge only the lanes whose i_mem_mask bit is 1; mask 4'b0000 writes nothing.
REQ-015 Read SHALL happen every cycle with no enable; o_mem_data at posedge N+1 reflects the address presented during cycle N, giving the single-cycle latency the core's 2-cycle load expects.
REQ-016 Read-during-write to the same word SHALL return the old (pre-write) contents.
REQ-017 MMIO offset 0 (LED): a write with mask[0]=1 SHALL load o_leds <= i_mem_data[7:0]; a read SHALL return {24'b0, o_leds}.
REQ-018 MMIO offset 1 (UART data): a write with mask[0]=1 while the transmitter is idle SHALL latch i_mem_data[7:0] and start a frame; a write while busy SHALL be silently dropped.
REQ-019 MMIO offset 2 (UART status): a read SHALL return {31'b0, busy}; writes SHALL be ignored.
REQ-020 MMIO offset 3 (cycle counter): the counter SHALL be 32 bits, increment every cycle, and wrap 0xFFFFFFFF->0; a read SHALL return the pre-edge value; any write with a nonzero mask SHALL clear it to 0 at that edge, overriding the increment.
REQ-021 Unmapped MMIO offsets SHALL read 0, and writes to them SHALL have no effect.
REQ-022 The UART FSM SHALL have states IDLE -> START -> DATA -> STOP -> IDLE.
REQ-023 Each UART state SHALL hold its line level for exactly CLK_PER_BIT cycles, counted by a baud counter.
REQ-024 In START the line SHALL be 0.
REQ-025 In DATA the block SHALL send 8 bits LSB first, using a 3-bit bit index.
REQ-026 In STOP the line SHALL be 1.
REQ-027 busy SHALL be 1 in every state except IDLE.
REQ-028 busy SHALL rise on the edge that accepts the write.
REQ-029 The first start-bit cycle SHALL be the cycle following the accepting edge.
REQ-030 The frame SHALL last 10*CLK_PER_BIT cycles.
REQ-031 A new frame SHALL be accepted on or after the edge at which the FSM returns to IDLE.

Reset
REQ-032 While rst=1 at posedge, the block SHALL clear o_mem_data to 0, o_leds to 0, and the counter to 0, and SHALL put the UART FSM in IDLE with o_uart_tx=1, busy=0 and the baud counter and bit index at 0.
REQ-033 RAM contents SHALL NOT be reset.
REQ-034 Reset asserted mid-frame SHALL abort the frame immediately, with the line high from the next cycle.
REQ-035 Stores presented while rst=1 SHALL still write RAM; MMIO writes presented while rst=1 SHALL be ignored.

Verification
REQ-036 Byte masks: write 0xDEADBEEF to word 5 with mask 1111, then 0x00001200 with mask 0010, then read word 5 -> 0xDEAD12EF one cycle after the address is presented.
REQ-037 Read-during-write: word 7=0x11111111; write 0x22222222 to word 7 while reading word 7 -> old value 0x11111111 on that cycle's read, then 0x22222222 on the next read.
REQ-038 Aliasing: with RAM_WORDS=1024, write 0xA5A5A5A5 to word 0x400, then read word 0 -> 0xA5A5A5A5.
REQ-039 UART: with CLK_PER_BIT=4, write 0x55 to offset 1 -> o_uart_tx low for 4 cycles, then 1,0,1,0,1,0,1,0 at 4 cycles each, then high for 4 cycles.
REQ-040 UART busy handling: a status read returns 1 during the frame; a second write of 0x0F mid-frame produces no second frame; status reads 0 after exactly 40 cycles.
REQ-041 Counter and reset: release rst, wait 10 cycles, read offset 3 -> 10; write offset 3 -> next read is 0; assert rst mid-frame -> o_uart_tx=1, o_leds=0, status=0 on the following cycle.

Source files
------------

// File: rtl/data_mem_bus.sv
// Data-side memory bus: word RAM with byte-lane stores, plus an MMIO window
// holding an LED register, a UART transmitter and a free-running cycle counter.
// All reads go through one registered output port with single-cycle latency.
module data_mem_bus #(
  parameter int RAM_WORDS   = 1024,
  parameter int CLK_PER_BIT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [29:0] i_mem_addr,
  input  logic [31:0] i_mem_data,
  input  logic        i_mem_we,
  input  logic [3:0]  i_mem_mask,
  output logic [31:0] o_mem_data,
  output logic [7:0]  o_leds,
  output logic        o_uart_tx
);

  localparam int IDX_W  = (RAM_WORDS > 1) ? $clog2(RAM_WORDS) : 1;
  localparam int BAUD_W = (CLK_PER_BIT > 1) ? $clog2(CLK_PER_BIT) : 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLK_PER_BIT - 1);
  localparam logic [BAUD_W-1:0] BAUD_ONE  = BAUD_W'(1);
  localparam logic [BAUD_W-1:0] BAUD_ZERO = BAUD_W'(0);

  typedef enum logic [1:0] {
    UART_IDLE  = 2'd0,
    UART_START = 2'd1,
    UART_DATA  = 2'd2,
    UART_STOP  = 2'd3
  } uart_state_t;

  // Storage and state
  logic [31:0]       mem_r [RAM_WORDS];
  logic [31:0]       cnt_r;
  uart_state_t       state_r;
  uart_state_t       state_next_s;
  logic [BAUD_W-1:0] baud_r;
  logic [BAUD_W-1:0] baud_next_s;
  logic [2:0]        bit_r;
  logic [2:0]        bit_next_s;
  logic [7:0]        data_r;
  logic [7:0]        data_next_s;
  logic              tx_next_s;

  // Decode
  logic              sel_mmio_s;
  logic [3:0]        mmio_off_s;
  logic [IDX_W-1:0]  ram_idx_s;
  logic              mmio_we_s;
  logic              led_we_s;
  logic              uart_we_s;
  logic              uart_accept_s;
  logic              cnt_clr_s;
  logic              busy_s;
  logic [31:0]       mmio_rd_s;
  logic              unused_addr_s;

  assign sel_mmio_s    = i_mem_addr[29];
  assign mmio_off_s    = i_mem_addr[3:0];
  assign ram_idx_s     = i_mem_addr[IDX_W-1:0];
  assign unused_addr_s = ^i_mem_addr[28:4];

  // MMIO side effects are suppressed while reset is held; RAM stores are not.
  assign mmio_we_s     = i_mem_we && sel_mmio_s && !rst;
  assign led_we_s      = mmio_we_s && (mmio_off_s == 4'd0) && i_mem_mask[0];
  assign uart_we_s     = mmio_we_s && (mmio_off_s == 4'd1) && i_mem_mask[0];
  assign cnt_clr_s     = mmio_we_s && (mmio_off_s == 4'd3) && (i_mem_mask != 4'b0000);
  assign busy_s        = (state_r != UART_IDLE);
  assign uart_accept_s = uart_we_s && !busy_s;

  // RAM byte-lane stores; contents are never reset and addresses alias modulo depth
  always_ff @(posedge clk) begin
    if (i_mem_we && !sel_mmio_s) begin
      for (int k = 0; k < 4; k++) begin
        if (i_mem_mask[k]) begin
          mem_r[ram_idx_s][8*k +: 8] <= i_mem_data[8*k +: 8];
        end
      end
    end
  end

  // MMIO read mux; the counter returns its value from before the current edge
  always_comb begin
    mmio_rd_s = 32'd0;
    case (mmio_off_s)
      4'd0:    mmio_rd_s = {24'd0, o_leds};
      4'd2:    mmio_rd_s = {31'd0, busy_s};
      4'd3:    mmio_rd_s = cnt_r;
      default: mmio_rd_s = 32'd0;
    endcase
  end

  // Registered load data; RAM read samples old contents on read-during-write
  always_ff @(posedge clk) begin
    if (rst) begin
      o_mem_data <= 32'd0;
    end else if (!sel_mmio_s) begin
      o_mem_data <= mem_r[ram_idx_s];
    end else begin
      o_mem_data <= mmio_rd_s;
    end
  end

  // LED register
  always_ff @(posedge clk) begin
    if (rst) begin
      o_leds <= 8'd0;
    end else if (led_we_s) begin
      o_leds <= i_mem_data[7:0];
    end
  end

  // Free-running cycle counter; a write clears it in place of the increment
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r <= 32'd0;
    end else if (cnt_clr_s) begin
      cnt_r <= 32'd0;
    end else begin
      cnt_r <= cnt_r + 32'd1;
    end
  end

  // UART next-state logic: each state holds for CLK_PER_BIT cycles
  always_comb begin
    state_next_s = state_r;
    baud_next_s  = baud_r;
    bit_next_s   = bit_r;
    data_next_s  = data_r;
    case (state_r)
      UART_IDLE: begin
        if (uart_accept_s) begin
          state_next_s = UART_START;
          baud_next_s  = BAUD_ZERO;
          bit_next_s   = 3'd0;
          data_next_s  = i_mem_data[7:0];
        end else begin
          state_next_s = UART_IDLE;
        end
      end
      UART_START: begin
        if (baud_r == BAUD_LAST) begin
          state_next_s = UART_DATA;
          baud_next_s  = BAUD_ZERO;
        end else begin
          baud_next_s  = baud_r + BAUD_ONE;
        end
      end
      UART_DATA: begin
        if (baud_r == BAUD_LAST) begin
          baud_next_s = BAUD_ZERO;
          if (bit_r == 3'd7) begin
            state_next_s = UART_STOP;
            bit_next_s   = 3'd0;
          end else begin
            bit_next_s   = bit_r + 3'd1;
          end
        end else begin
          baud_next_s = baud_r + BAUD_ONE;
        end
      end
      UART_STOP: begin
        if (baud_r == BAUD_LAST) begin
          state_next_s = UART_IDLE;
          baud_next_s  = BAUD_ZERO;
        end else begin
          baud_next_s  = baud_r + BAUD_ONE;
        end
      end
      default: begin
        state_next_s = UART_IDLE;
        baud_next_s  = BAUD_ZERO;
        bit_next_s   = 3'd0;
      end
    endcase
  end

  // Line level derived from the next state so the start bit begins right after acceptance
  always_comb begin
    tx_next_s = 1'b1;
    case (state_next_s)
      UART_START: tx_next_s = 1'b0;
      UART_DATA:  tx_next_s = data_next_s[bit_next_s];
      default:    tx_next_s = 1'b1;
    endcase
  end

  // UART state register; reset aborts any frame and drives the line high
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= UART_IDLE;
      baud_r    <= BAUD_ZERO;
      bit_r     <= 3'd0;
      data_r    <= 8'd0;
      o_uart_tx <= 1'b1;
    end else begin
      state_r   <= state_next_s;
      baud_r    <= baud_next_s;
      bit_r     <= bit_next_s;
      data_r    <= data_next_s;
      o_uart_tx <= tx_next_s;
    end
  end

endmodule

// File: tb/tb_data_mem_bus.sv
// Directed self-checking bench for data_mem_bus (CLK_PER_BIT=4, RAM_WORDS=1024).
module tb_data_mem_bus;

  localparam logic [29:0] MMIO = 30'h2000_0000;

  logic        clk;
  logic        rst;
  logic [29:0] i_mem_addr;
  logic [31:0] i_mem_data;
  logic        i_mem_we;
  logic [3:0]  i_mem_mask;
  logic [31:0] o_mem_data;
  logic [7:0]  o_leds;
  logic        o_uart_tx;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        we;
    logic [3:0]  mask;
    logic [29:0] addr;
    logic [31:0] data;
    logic        chk;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [22];

  data_mem_bus #(.RAM_WORDS(1024), .CLK_PER_BIT(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .i_mem_addr (i_mem_addr),
    .i_mem_data (i_mem_data),
    .i_mem_we   (i_mem_we),
    .i_mem_mask (i_mem_mask),
    .o_mem_data (o_mem_data),
    .o_leds     (o_leds),
    .o_uart_tx  (o_uart_tx)
  );

  // Free-running clock, period 10
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One clock: inputs are driven at negedge, outputs sampled at the following negedge
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic uart_bit(input logic [7:0] d, input int i);
    int b;
    b = i / 4;
    if (b == 0) return 1'b0;
    else if (b <= 8) return d[b-1];
    else return 1'b1;
  endfunction

  task automatic drive(input logic we, input logic [3:0] mask, input logic [29:0] addr,
                       input logic [31:0] data);
    i_mem_we   = we;
    i_mem_mask = mask;
    i_mem_addr = addr;
    i_mem_data = data;
  endtask

  // Directed test sequence
  initial begin
    vecs[0]  = '{1'b1, 4'hF, 30'd5,        32'hDEADBEEF, 1'b0, 32'h0};
    vecs[1]  = '{1'b1, 4'h2, 30'd5,        32'h00001200, 1'b0, 32'h0};
    vecs[2]  = '{1'b0, 4'h0, 30'd5,        32'h0,        1'b1, 32'hDEAD12EF};
    vecs[3]  = '{1'b1, 4'hF, 30'd7,        32'h11111111, 1'b0, 32'h0};
    vecs[4]  = '{1'b1, 4'hF, 30'd7,        32'h22222222, 1'b1, 32'h11111111};
    vecs[5]  = '{1'b0, 4'h0, 30'd7,        32'h0,        1'b1, 32'h22222222};
    vecs[6]  = '{1'b1, 4'hF, 30'h400,      32'hA5A5A5A5, 1'b0, 32'h0};
    vecs[7]  = '{1'b0, 4'h0, 30'd0,        32'h0,        1'b1, 32'hA5A5A5A5};
    vecs[8]  = '{1'b1, 4'h0, 30'd5,        32'hFFFFFFFF, 1'b0, 32'h0};
    vecs[9]  = '{1'b0, 4'h0, 30'd5,        32'h0,        1'b1, 32'hDEAD12EF};
    vecs[10] = '{1'b0, 4'h0, 30'd9,        32'h0,        1'b1, 32'h12345678};
    vecs[11] = '{1'b1, 4'h1, MMIO + 30'd0, 32'h000000C3, 1'b1, 32'h0};
    vecs[12] = '{1'b0, 4'h0, MMIO + 30'd0, 32'h0,        1'b1, 32'h000000C3};
    vecs[13] = '{1'b1, 4'h2, MMIO + 30'd0, 32'h000000FF, 1'b1, 32'h000000C3};
    vecs[14] = '{1'b0, 4'h0, MMIO + 30'd0, 32'h0,        1'b1, 32'h000000C3};
    vecs[15] = '{1'b1, 4'hF, MMIO + 30'd5, 32'hFFFFFFFF, 1'b1, 32'h0};
    vecs[16] = '{1'b0, 4'h0, MMIO + 30'd5, 32'h0,        1'b1, 32'h0};
    vecs[17] = '{1'b0, 4'h0, MMIO + 30'd2, 32'h0,        1'b1, 32'h0};
    vecs[18] = '{1'b0, 4'h0, 30'd0,        32'h0,        1'b1, 32'hA5A5A5A5};
    vecs[19] = '{1'b1, 4'h9, 30'd7,        32'hAB0000CD, 1'b0, 32'h0};
    vecs[20] = '{1'b0, 4'h0, 30'd7,        32'h0,        1'b1, 32'hAB2222CD};
    vecs[21] = '{1'b0, 4'h0, 30'd5,        32'h0,        1'b1, 32'hDEAD12EF};

    // Reset: RAM store still lands, LED write is ignored
    rst = 1'b1;
    drive(1'b1, 4'hF, 30'd9, 32'h12345678);
    step();
    drive(1'b1, 4'h1, MMIO + 30'd0, 32'h000000FF);
    step();
    drive(1'b0, 4'h0, 30'd0, 32'h0);
    step();
    check("rst_mem_data", o_mem_data, 32'h0);
    check("rst_leds", {24'd0, o_leds}, 32'h0);
    check("rst_tx", {31'd0, o_uart_tx}, 32'h1);

    // Counter: 10 cycles after release reads 10; clear then reads 0
    rst = 1'b0;
    repeat (10) step();
    drive(1'b0, 4'h0, MMIO + 30'd3, 32'h0);
    step();
    check("cnt_10", o_mem_data, 32'd10);
    drive(1'b1, 4'hF, MMIO + 30'd3, 32'h0);
    step();
    check("cnt_pre_clear", o_mem_data, 32'd11);
    drive(1'b0, 4'h0, MMIO + 30'd3, 32'h0);
    step();
    check("cnt_cleared", o_mem_data, 32'd0);

    // Table of RAM / MMIO vectors
    for (int i = 0; i < 22; i++) begin
      drive(vecs[i].we, vecs[i].mask, vecs[i].addr, vecs[i].data);
      step();
      if (vecs[i].chk) check($sformatf("vec%0d", i), o_mem_data, vecs[i].exp);
    end
    drive(1'b0, 4'h0, 30'd0, 32'h0);
    check("leds_c3", {24'd0, o_leds}, 32'h000000C3);

    // UART frame 0x55 with a dropped mid-frame write and busy status reads
    drive(1'b1, 4'h1, MMIO + 30'd1, 32'h00000055);
    step();
    for (int i = 0; i < 40; i++) begin
      check($sformatf("tx55_c%0d", i), {31'd0, o_uart_tx}, {31'd0, uart_bit(8'h55, i)});
      if (i == 20) drive(1'b1, 4'h1, MMIO + 30'd1, 32'h0000000F);
      else         drive(1'b0, 4'h0, MMIO + 30'd2, 32'h0);
      step();
      if (i != 20) check($sformatf("busy_c%0d", i), o_mem_data, 32'd1);
    end
    drive(1'b0, 4'h0, MMIO + 30'd2, 32'h0);
    check("tx_idle_after", {31'd0, o_uart_tx}, 32'd1);
    step();
    check("status_idle_40", o_mem_data, 32'd0);
    for (int i = 0; i < 44; i++) begin
      step();
      check($sformatf("no_frame2_c%0d", i), {31'd0, o_uart_tx}, 32'd1);
    end

    // Reset mid-frame aborts the frame and clears LEDs
    drive(1'b1, 4'h1, MMIO + 30'd1, 32'h000000A0);
    step();
    drive(1'b0, 4'h0, 30'd0, 32'h0);
    repeat (5) step();
    check("midframe_low", {31'd0, o_uart_tx}, 32'd0);
    rst = 1'b1;
    step();
    check("abort_tx", {31'd0, o_uart_tx}, 32'd1);
    check("abort_leds", {24'd0, o_leds}, 32'h0);
    check("abort_mem_data", o_mem_data, 32'h0);
    rst = 1'b0;
    drive(1'b0, 4'h0, MMIO + 30'd2, 32'h0);
    step();
    check("abort_status", o_mem_data, 32'd0);

    // A fresh frame is accepted after the abort
    drive(1'b1, 4'h1, MMIO + 30'd1, 32'h00000001);
    step();
    check("restart_start_bit", {31'd0, o_uart_tx}, 32'd0);
    drive(1'b0, 4'h0, MMIO + 30'd2, 32'h0);
    step();
    check("restart_busy", o_mem_data, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
